// File: rtl/mem_access_ctrl.sv
// Memory access controller: takes one pipeline load/store request at a time and runs it on a
// simple req/ack bus. Misaligned requests return at once; a bus that never acks times out.
package mem_access_pkg;
    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_t;
endpackage

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  mem_size_t        req_size,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [3:0]       req_be,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [1:0]       rsp_addr_low,
    output logic             rsp_misaligned,
    output logic             rsp_fault
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           state_q, state_d;
    logic             wr_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] rdata_q;
    logic             misal_q;
    logic             fault_q;
    logic [7:0]       cnt_q;

    logic accept;
    logic misaligned;
    logic timeout_hit;

    assign accept      = req_valid && req_ready;
    // cnt_q holds the number of ack-less BUS cycles already completed
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            MEM_SIZE_HALF: misaligned = req_addr[0];
            MEM_SIZE_WORD: misaligned = |req_addr[1:0];
            default:       misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = misaligned ? RESP : BUS;
            BUS:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            misal_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            rdata_q <= '0;
            misal_q <= misaligned;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == BUS) begin
            // a late ack on the final count still completes normally
            if (mem_ack) begin
                if (!wr_q) rdata_q <= mem_rdata;
            end else if (timeout_hit) begin
                fault_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign mem_req        = (state_q == BUS);
    assign mem_we         = mem_req && wr_q;
    assign mem_addr       = mem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata      = mem_req ? wdata_q : '0;
    assign mem_be         = mem_req ? (wr_q ? be_q : 4'b1111) : 4'b0000;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rsp_valid ? rdata_q : '0;
    assign rsp_addr_low   = rsp_valid ? addr_q[1:0] : 2'b00;
    assign rsp_misaligned = rsp_valid && misal_q;
    assign rsp_fault      = rsp_valid && fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single transactions plus hand-written
// sequences for response backpressure, stray acks and mid-transaction reset.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    mem_size_t   req_size = MEM_SIZE_WORD;
    logic [3:0]  req_be = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_misaligned, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_addr_low;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_be(req_be),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_addr_low(rsp_addr_low), .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        mem_size_t   size;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_at;     // mem_req cycle (1-based) carrying mem_ack; 0 = never
        logic [31:0] rdata;
        int          exp_cyc;    // cycles mem_req is high
        logic [31:0] exp_maddr;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_low;
        logic        exp_mis;
        logic        exp_fault;
        int          exp_lat;    // cycles from accept edge to first rsp_valid cycle
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_size  = v.size;
        req_wdata = v.wdata;
        req_be    = v.be;
        mem_rdata = v.rdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Runs the bus side until rsp_valid, then checks and completes the response
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc, lat;
        bit  done;
        cyc = 0; lat = 0; done = 0;
        issue(v);
        for (int i = 0; i < 20 && !done; i++) begin
            lat++;
            if (rsp_valid) begin
                done = 1;
            end else begin
                if (mem_req) begin
                    cyc++;
                    if (cyc == 1) begin
                        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_maddr);
                        chk($sformatf("v%0d_mem_be", idx), 32'(mem_be), 32'(v.exp_mbe));
                        chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.wr));
                        chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
                    end
                    mem_ack = (cyc == v.ack_at);
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        chk($sformatf("v%0d_rsp_seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_mem_cycles", idx), 32'(cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_addr_low", idx), 32'(rsp_addr_low), 32'(v.exp_low));
        chk($sformatf("v%0d_rsp_mis", idx), 32'(rsp_misaligned), 32'(v.exp_mis));
        chk($sformatf("v%0d_rsp_fault", idx), 32'(rsp_fault), 32'(v.exp_fault));
        chk($sformatf("v%0d_req_ready_resp", idx), 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_done", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_back_idle", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] hold_rdata;
        int wait_cyc;

        //          wr    addr        size           wdata         be       ack rdata         cyc maddr       mbe      rsp_rdata     low   mis   flt   lat
        vecs[0] = '{1'b0, 32'h100, MEM_SIZE_WORD, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b1, 32'h203, MEM_SIZE_BYTE, 32'h5A5A5A5A, 4'b1000, 3, 32'h0,        3, 32'h200, 4'b1000, 32'h0,        2'd3, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h101, MEM_SIZE_HALF, 32'h0,        4'b0000, 1, 32'h55555555, 0, 32'h0,   4'b0000, 32'h0,        2'd1, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h300, MEM_SIZE_WORD, 32'h0,        4'b0000, 0, 32'hAAAAAAAA, 4, 32'h300, 4'b1111, 32'h0,        2'd0, 1'b0, 1'b1, 5};
        vecs[4] = '{1'b0, 32'h304, MEM_SIZE_WORD, 32'h0,        4'b0000, 4, 32'h12345678, 4, 32'h304, 4'b1111, 32'h12345678, 2'd0, 1'b0, 1'b0, 5};
        vecs[5] = '{1'b0, 32'h102, MEM_SIZE_HALF, 32'h0,        4'b0000, 2, 32'hCAFEF00D, 2, 32'h100, 4'b1111, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 3};
        vecs[6] = '{1'b0, 32'h105, MEM_SIZE_WORD, 32'h0,        4'b0000, 1, 32'h0,        0, 32'h0,   4'b0000, 32'h0,        2'd1, 1'b1, 1'b0, 1};
        vecs[7] = '{1'b1, 32'h40,  MEM_SIZE_WORD, 32'hA1B2C3D4, 4'b1111, 1, 32'hFFFFFFFF, 1, 32'h40,  4'b1111, 32'h0,        2'd0, 1'b0, 1'b0, 2};
        vecs[8] = '{1'b0, 32'h3,   MEM_SIZE_BYTE, 32'h0,        4'b0000, 1, 32'h11223344, 1, 32'h0,   4'b1111, 32'h11223344, 2'd3, 1'b0, 1'b0, 2};

        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Response backpressure: payload held, new requests refused
        issue(vecs[0]);
        mem_ack = mem_req;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("bp_rsp_valid0", 32'(rsp_valid), 32'd1);
        hold_rdata = rsp_rdata;
        chk("bp_rdata0", hold_rdata, 32'hDEADBEEF);
        req_valid = 1'b1;
        req_addr  = 32'h400;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_rsp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp_low_%0d", i), 32'(rsp_addr_low), 32'd0);
            chk($sformatf("bp_req_ready_%0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("bp_mem_req_%0d", i), 32'(mem_req), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_done", 32'(rsp_valid), 32'd0);

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_ready", 32'(req_ready), 32'd1);
        chk("stray_ack_rsp", 32'(rsp_valid), 32'd0);

        // Reset during BUS drops mem_req with no clock edge
        issue(vecs[3]);
        chk("mid_rst_bus", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || mem_req) wait_cyc++;
        end
        chk("post_rst_quiet", 32'(wait_cyc), 32'd0);

        // Normal operation resumes after reset
        run_vec(vecs[0], 90);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum bus-wait cycles (1..255).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  WIDTH  byte address.
REQ-009 SHALL have port req_size  input  mem_size_t  MEM_SIZE_BYTE/HALF/WORD.
REQ-010 SHALL have port req_wdata  input  WIDTH  lane-replicated store data.
REQ-011 SHALL have port req_be  input  4  store byte enables.
REQ-012 SHALL have ports mem_req/mem_we (output 1), mem_addr (output WIDTH), mem_wdata (output WIDTH), mem_be (output 4)  bus request.
REQ-013 SHALL have ports mem_ack  input  1, mem_rdata  input  WIDTH  bus completion and read data.
REQ-014 SHALL have ports rsp_valid (output 1), rsp_ready (input 1), rsp_rdata (output WIDTH), rsp_addr_low (output 2), rsp_misaligned (output 1), rsp_fault (output 1)  response to load extraction stage.

Function
REQ-015 SHALL implement states IDLE, BUS, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on the edge where req_valid && req_ready, registering write, addr, size, wdata, be.
REQ-017 SHALL flag misalignment: HALF with addr[0]=1, or WORD with addr[1:0]!=0; BYTE never misaligned.
REQ-018 SHALL, on accepting a misaligned request, go IDLE->RESP with rsp_misaligned=1, rsp_rdata=0, and never assert mem_req.
REQ-019 SHALL, on accepting an aligned request, go IDLE->BUS; mem_req=1 from the next cycle.
REQ-020 SHALL drive mem_addr = {addr[WIDTH-1:2],2'b00}, mem_we = req_write, mem_wdata = registered wdata, mem_be = registered be for stores and 4'b1111 for loads, all stable while mem_req=1.
REQ-021 SHALL hold mem_req=1 in BUS until mem_ack=1; on mem_ack capture mem_rdata (loads only) and go BUS->RESP, mem_req=0 next cycle.
REQ-022 SHALL count consecutive BUS cycles without mem_ack; when TIMEOUT such cycles elapse, go RESP with rsp_fault=1, rsp_rdata=0; mem_ack in the same cycle as the final count wins (normal completion).
REQ-023 SHALL assert rsp_valid in RESP and hold rsp_rdata, rsp_addr_low=addr[1:0], rsp_misaligned, rsp_fault stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-024 SHALL drive rsp_rdata=0 for stores.
REQ-025 SHALL ignore mem_ack outside BUS and ignore req_valid outside IDLE.
REQ-026 SHALL give minimum aligned latency: accept at edge N, mem_req high cycle N+1, ack in N+1 gives rsp_valid in N+2; new request acceptable the cycle after response handshake (no bypass).
REQ-027 SHALL clear the timeout counter on every entry to BUS.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE and all outputs to 0 except req_ready=1, asynchronously.
REQ-029 SHALL, on reset mid-transaction, drop mem_req immediately and discard the in-flight request with no response.
REQ-030 SHALL resume with IDLE behaviour on the first rising edge after rst_n deasserts.

Verification
REQ-031 Load WORD addr 0x100, mem_ack one cycle after mem_req, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 4'b1111, rsp_rdata 0xDEADBEEF, rsp_addr_low 0, rsp_valid at N+2.
REQ-032 Store BYTE addr 0x203, wdata 0x5A5A5A5A, be 4'b1000, ack after 3 cycles -> mem_addr 0x200, mem_we 1, mem_be 4'b1000, mem_req 3 cycles, rsp_rdata 0.
REQ-033 Load HALF addr 0x101 -> mem_req never asserts, rsp_misaligned=1 one cycle after accept.
REQ-034 TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then rsp_fault=1; repeat with ack on 4th cycle -> rsp_fault=0.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid and payload stable, req_ready=0 throughout.
REQ-036 rst_n asserted during BUS -> mem_req=0 and req_ready=1 without clock edge; no rsp_valid after release.
